// File: rtl/banked_spram_pkg.sv
// Shared types and helpers for the banked single-port SRAM main memory.
package banked_spram_pkg;

  localparam int MACRO_W = 16;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // A macro write-enables nibbles, so each byte-enable bit covers two of them.
  function automatic logic [3:0] nib_mask(input logic [1:0] byte_en);
    return {{2{byte_en[1]}}, {2{byte_en[0]}}};
  endfunction

endpackage

// File: rtl/spram_macro.sv
// One 16-bit-wide single-port SRAM macro: behavioural model by default,
// hard SP256K primitive when built for the FPGA.
module spram_macro
  import banked_spram_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_cs,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [MACRO_W-1:0] i_wdata,
  input  logic [3:0]         i_maskwe,
  output logic [MACRO_W-1:0] o_rdata
);

`ifdef FPGA_SP256K
  SP256K u_sp256k (
    .AD       (i_addr),
    .DI       (i_wdata),
    .MASKWE   (i_maskwe),
    .WE       (i_we),
    .CS       (i_cs),
    .CK       (clk),
    .STDBY    (1'b0),
    .SLEEP    (1'b0),
    .PWROFF_N (1'b1),
    .DO       (o_rdata)
  );
`else
  logic [MACRO_W-1:0] r_mem [DEPTH];
  logic [MACRO_W-1:0] r_rdata;

  // Nibble-masked write, or registered read that holds between reads.
  always_ff @(posedge clk) begin
    if (i_cs) begin
      if (i_we) begin
        for (int k = 0; k < 4; k++) begin
          if (i_maskwe[k]) begin
            r_mem[i_addr][k*4 +: 4] <= i_wdata[k*4 +: 4];
          end
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/banked_spram.sv
// Word-addressed main memory built from an N_BANKS x COLS grid of 16-bit
// macros, with valid/ready requests, in-order responses and a zero-clear sweep.
module banked_spram
  import banked_spram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int N_BANKS     = 2,
  parameter int MACRO_DEPTH = 16384,
  parameter int OUT_REG     = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic                req_we,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_mask,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int COLS  = DATA_W / MACRO_W;
  localparam int OFS   = $clog2(DATA_W / 8);
  localparam int WORDS = N_BANKS * MACRO_DEPTH;
  localparam int AW    = $clog2(WORDS);
  localparam int MA_W  = $clog2(MACRO_DEPTH);
  localparam int BK_W  = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int HI    = OFS + AW;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [MA_W-1:0]     r_clr_cnt;
  logic                r_s1_valid;
  logic                r_s1_we;
  logic                r_s1_err;
  logic [BK_W-1:0]     r_bank;

  logic [AW-1:0]       w_word_addr;
  logic [MA_W-1:0]     w_mac_addr;
  logic [BK_W-1:0]     w_bank;
  logic                w_oor;
  logic                w_acc;
  logic                w_rd_resp;
  logic                w_unused_addr;

  logic [N_BANKS-1:0]  w_cs;
  logic                w_we;
  logic [MA_W-1:0]     w_maddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [4*COLS-1:0]   w_maskwe;
  logic [MACRO_W-1:0]  w_rd [N_BANKS][COLS];
  logic [DATA_W-1:0]   w_mux;

  assign w_word_addr   = req_addr[OFS +: AW];
  assign w_mac_addr    = w_word_addr[MA_W-1:0];
  assign w_oor         = |req_addr[31:HI];
  assign w_unused_addr = ^req_addr[OFS-1:0];
  assign req_ready     = (r_state == ST_READY);
  assign init_done     = (r_state == ST_READY);
  assign w_acc         = req_valid & req_ready;
  assign w_rd_resp     = r_s1_valid & ~r_s1_we & ~r_s1_err;

  if (N_BANKS > 1) begin : g_bank_sel
    assign w_bank = w_word_addr[AW-1 -: BK_W];
  end else begin : g_bank_one
    assign w_bank = 1'b0;
  end

  // FSM next state: the sweep ends once the last macro row has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == MA_W'(MACRO_DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // State register and clear-sweep counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      r_clr_cnt <= {MA_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= (r_state == ST_CLEAR) ? r_clr_cnt + MA_W'(1) : {MA_W{1'b0}};
    end
  end

  // Macro control: all-bank zero writes while clearing, one bank when serving.
  always_comb begin
    w_cs     = {N_BANKS{1'b0}};
    w_we     = 1'b0;
    w_maddr  = {MA_W{1'b0}};
    w_wdata  = {DATA_W{1'b0}};
    w_maskwe = {(4*COLS){1'b0}};
    case (r_state)
      ST_CLEAR: begin
        w_cs     = {N_BANKS{1'b1}};
        w_we     = 1'b1;
        w_maddr  = r_clr_cnt;
        w_maskwe = {(4*COLS){1'b1}};
      end
      ST_READY: begin
        for (int b = 0; b < N_BANKS; b++) begin
          w_cs[b] = w_acc & ~w_oor & (w_bank == BK_W'(b));
        end
        w_we    = req_we;
        w_maddr = w_mac_addr;
        w_wdata = req_wdata;
        for (int j = 0; j < COLS; j++) begin
          w_maskwe[j*4 +: 4] = nib_mask(req_mask[j*2 +: 2]);
        end
      end
      default: begin
        w_cs = {N_BANKS{1'b0}};
      end
    endcase
  end

  // First response stage; the bank is latched only for in-range reads so the
  // read mux keeps pointing at the data last returned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_err   <= 1'b0;
      r_bank     <= {BK_W{1'b0}};
    end else begin
      r_s1_valid <= w_acc;
      r_s1_we    <= req_we;
      r_s1_err   <= w_acc & w_oor;
      if (w_acc & ~req_we & ~w_oor) begin
        r_bank <= w_bank;
      end
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    for (genvar j = 0; j < COLS; j++) begin : g_col
      spram_macro #(
        .DEPTH (MACRO_DEPTH)
      ) u_macro (
        .clk      (clk),
        .i_cs     (w_cs[b]),
        .i_we     (w_we),
        .i_addr   (w_maddr),
        .i_wdata  (w_wdata[j*MACRO_W +: MACRO_W]),
        .i_maskwe (w_maskwe[j*4 +: 4]),
        .o_rdata  (w_rd[b][j])
      );
    end
  end

  // Read mux across banks using the captured bank index.
  always_comb begin
    w_mux = {DATA_W{1'b0}};
    for (int j = 0; j < COLS; j++) begin
      w_mux[j*MACRO_W +: MACRO_W] = w_rd[r_bank][j];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              r_s2_valid;
    logic              r_s2_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    // Registered output stage; read data only moves on read responses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s2_valid  <= 1'b0;
        r_s2_err    <= 1'b0;
        r_rsp_rdata <= {DATA_W{1'b0}};
      end else begin
        r_s2_valid <= r_s1_valid;
        r_s2_err   <= r_s1_valid & r_s1_err;
        if (w_rd_resp) begin
          r_rsp_rdata <= w_mux;
        end
      end
    end

    assign rsp_valid = r_s2_valid;
    assign rsp_err   = r_s2_err;
    assign rsp_rdata = r_rsp_rdata;
  end else begin : g_no_out_reg
    logic [DATA_W-1:0] r_hold;

    // Remembers the last read data so other responses leave rsp_rdata alone.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_hold <= {DATA_W{1'b0}};
      end else begin
        r_hold <= w_rd_resp ? w_mux : r_hold;
      end
    end

    assign rsp_valid = r_s1_valid;
    assign rsp_err   = r_s1_err;
    assign rsp_rdata = w_rd_resp ? w_mux : r_hold;
  end

endmodule

// File: tb/tb_banked_spram.sv
// Scoreboard bench: two instances (OUT_REG=0 and OUT_REG=1) share stimulus;
// each has its own expected-response queue checked on rsp_valid.
module tb_banked_spram;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;

  logic        ready0, rsp_valid0, err0, done0;
  logic [31:0] rdata0;
  logic        ready1, rsp_valid1, err1, done1;
  logic [31:0] rdata1;

  always #5 clk = ~clk;

  banked_spram #(.DATA_W(32), .N_BANKS(2), .MACRO_DEPTH(16384), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_mask(req_mask), .rsp_valid(rsp_valid0),
    .rsp_rdata(rdata0), .rsp_err(err0), .init_done(done0)
  );

  banked_spram #(.DATA_W(32), .N_BANKS(2), .MACRO_DEPTH(16384), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_mask(req_mask), .rsp_valid(rsp_valid1),
    .rsp_rdata(rdata1), .rsp_err(err1), .init_done(done1)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [int];
  logic [31:0] last_rd = 32'h0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          n_rsp0 = 0;
  int          n_rsp1 = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin : mon0
    exp_t e;
    #2;
    if (rsp_valid0) begin
      n_rsp0++;
      if (q0.size() == 0) begin
        check_eq("rsp0_unexpected", rsp_valid0, 1'b0);
      end else begin
        e = q0.pop_front();
        check_eq("rsp0_err", err0, e.err);
        check_eq("rsp0_rdata", rdata0, e.rdata);
        check_eq("rsp0_latency", cyc - e.acc, 1);
      end
    end
  end

  always @(posedge clk) begin : mon1
    exp_t e;
    #2;
    if (rsp_valid1) begin
      n_rsp1++;
      if (q1.size() == 0) begin
        check_eq("rsp1_unexpected", rsp_valid1, 1'b0);
      end else begin
        e = q1.pop_front();
        check_eq("rsp1_err", err1, e.err);
        check_eq("rsp1_rdata", rdata1, e.rdata);
        check_eq("rsp1_latency", cyc - e.acc, 2);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] m);
    exp_t        e;
    int          w;
    logic        oor;
    logic [31:0] cur;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = m;
    check_eq("ready_at_issue", {ready0, ready1}, 2'b11);
    oor = (addr[31:17] != 15'h0);
    w   = int'(addr[16:2]);
    cur = model.exists(w) ? model[w] : 32'h0;
    e.err   = oor;
    e.acc   = cyc;
    e.rdata = last_rd;
    if (!oor) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) cur[b*8 +: 8] = wd[b*8 +: 8];
        end
        model[w] = cur;
      end else begin
        e.rdata = cur;
        last_rd = cur;
      end
    end
    q0.push_back(e);
    q1.push_back(e);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check_eq({tag, "_q0_empty"}, q0.size(), 0);
    check_eq({tag, "_q1_empty"}, q1.size(), 0);
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    q0.delete();
    q1.delete();
    model.delete();
    last_rd = 32'h0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int cnt   = 0;
    int early = 0;
    while (!done0 && cnt < 20000) begin
      @(posedge clk);
      #2;
      cnt++;
      if (!done0 && (ready0 | ready1)) early++;
    end
    check_eq({tag, "_clear_cycles"}, cnt, 16384);
    check_eq({tag, "_ready_early"}, early, 0);
    check_eq({tag, "_done1"}, done1, 1'b1);
    check_eq({tag, "_ready"}, {ready0, ready1}, 2'b11);
  endtask

  initial begin : watchdog
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stim
    logic [31:0] addrs [8];
    int          b0, b1;
    addrs = '{32'h0000_0000, 32'h0000_0004, 32'h0000_FFFC, 32'h0001_0000,
              32'h0001_0004, 32'h0001_FFFC, 32'h0002_0000, 32'h8000_0004};
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_mask = 4'h0;

    #12;
    check_eq("rst_ready", {ready0, ready1}, 2'b00);
    check_eq("rst_done", {done0, done1}, 2'b00);
    check_eq("rst_rsp_valid", {rsp_valid0, rsp_valid1}, 2'b00);
    check_eq("rst_rsp_err", {err0, err1}, 2'b00);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("init");

    // Cleared memory reads back as zero.
    issue(1'b0, 32'h0001_FFFC, 32'h0, 4'h0);
    drain("clear_read");

    // Bank boundary, then back-to-back reads on both sides of it.
    issue(1'b1, 32'h0000_FFFC, 32'hDEAD_BEEF, 4'hF);
    issue(1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF);
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'h0);
    issue(1'b0, 32'h0001_0000, 32'h0, 4'h0);
    drain("bank_boundary");

    // Byte masks: expect 0xFF00FF00.
    issue(1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF);
    issue(1'b1, 32'h0000_0100, 32'h0000_0000, 4'h5);
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    drain("byte_mask");

    // Read immediately after write to the same address.
    issue(1'b1, 32'h0001_2340, 32'h1357_9BDF, 4'hF);
    issue(1'b0, 32'h0001_2340, 32'h0, 4'h0);
    drain("raw");

    // Eight back-to-back reads spread across both banks.
    for (int i = 0; i < 8; i++) issue(1'b1, 32'(i) * 32'h0000_4004, 32'hA5A5_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 8; i++) issue(1'b0, 32'(i) * 32'h0000_4004, 32'h0, 4'h0);
    drain("stream");

    // Out of range: error response, no aliasing write into word 0.
    issue(1'b1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF);
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'h0);
    issue(1'b0, 32'h0002_0000, 32'h0, 4'h0);
    issue(1'b1, 32'h0002_0000, 32'h1234_5678, 4'hF);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);
    drain("out_of_range");

    // Mixed random traffic with gaps.
    for (int i = 0; i < 48; i++) begin
      issue(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 7)], $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain("random");

    // Reset while a read is in flight: nothing may come out.
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = 1'b0;
    q0.delete();
    q1.delete();
    model.delete();
    last_rd = 32'h0;
    b0 = n_rsp0;
    b1 = n_rsp1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check_eq("inflight_rsp0", n_rsp0 - b0, 0);
    check_eq("inflight_rsp1", n_rsp1 - b1, 0);
    check_eq("inflight_clearing", done0, 1'b0);

    // Reset partway through a sweep restarts it from the beginning.
    apply_reset(2);
    repeat (5000) @(posedge clk);
    apply_reset(2);
    wait_init("reclear");

    // The sweep wiped data written earlier.
    issue(1'b0, 32'h0000_FFFC, 32'h0, 4'h0);
    issue(1'b0, 32'h0001_0000, 32'h0, 4'h0);
    drain("post_clear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_spram.md
Name: banked_spram

Overview:
- Parametrised word-addressed main memory built from a grid of 16-bit-wide single-port SRAM macros.
- Banks select on the upper word-address bits; columns tile the data width.
- Adds features to the fixed 128KB iCE40UP5K memory:
  - valid/ready request and response handshake
  - optional output register stage
  - post-reset zero-clear sweep
  - out-of-range error response
- Sits between the core's data/instruction bus arbiter and the physical SRAM macros.

Parameters:
- DATA_W, 32: data width in bits; a multiple of 16.
- N_BANKS, 2: number of stacked banks; a power of two, at least 1.
- MACRO_DEPTH, 16384: words per macro; a power of two.
- OUT_REG, 0: 1 adds a registered read-data stage (+1 cycle latency).
- INIT_CLEAR, 1: 1 sweeps all memory to zero after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address; low log2(DATA_W/8) bits ignored.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_W  write data.
- req_mask  in  DATA_W/8  byte write enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; holds its last value when not a read response.
- rsp_err  out  1  qualifies rsp_valid; address out of range.
- init_done  out  1  clear sweep complete; memory usable.

Behaviour:
- Reset is asynchronous and active-high on rst.
  - All outputs go to 0.
  - FSM goes to CLEAR if INIT_CLEAR, else READY.
  - Pipeline valids and the clear counter go to 0.
- Derived constants:
  - COLS = DATA_W/16
  - WORDS = N_BANKS*MACRO_DEPTH
  - word_addr = req_addr[OFS +: log2(WORDS)], where OFS = log2(DATA_W/8)
  - bank index = top log2(N_BANKS) bits of word_addr
  - macro address = low log2(MACRO_DEPTH) bits of word_addr
- FSM states:
  - CLEAR:
    - All macros are chip-selected, write-enabled with full mask and zero data, at address clr_cnt.
    - clr_cnt increments each cycle.
    - When clr_cnt reaches MACRO_DEPTH-1, that write completes and the FSM moves to READY the next cycle.
    - Sweep takes MACRO_DEPTH cycles.
    - req_ready = 0 and init_done = 0 throughout.
  - READY:
    - req_ready = 1 and init_done = 1.
    - A request is accepted on req_valid & req_ready.
    - One request may be accepted every cycle, with no bubbles.
    - No other states.
- Write path:
  - Only the selected bank is chip-selected.
  - Each macro (column j) gets MASKWE = {2{mask[2j+1]}, 2{mask[2j]}}, one bit per nibble.
  - rsp_valid pulses with rsp_err = 0 exactly 1+OUT_REG cycles after acceptance.
  - rsp_rdata is unchanged by a write response.
- Read path:
  - Bank index is captured into a register only on an accepted read.
  - The read mux uses that captured index.
  - Data is valid 1 cycle after acceptance, or 2 cycles if OUT_REG=1.
  - rsp_rdata updates only on read responses.
- Out of range: word_addr >= WORDS can only occur when req_addr has bits set above OFS+log2(WORDS).
  - No macro is selected and no write occurs.
  - Response follows the same latency with rsp_err = 1 and rsp_rdata unchanged.
- Ordering: responses return strictly in request order.
  - No backpressure on the response side; the consumer must accept.
- Read-after-write to the same address on consecutive cycles returns the new data.
  - This holds because the macro write completes before the next read samples.
- Simultaneous events:
  - rst asserted mid-CLEAR restarts the sweep from 0.
  - rst asserted mid-pipeline drops in-flight responses, with no spurious rsp_valid.
- Unused macro pins: STDBY = 0, SLEEP = 0, PWROFF_N = 1.

Decomposition:
- Shared package banked_spram_pkg holds:
  - the state enum (CLEAR, READY)
  - the macro data width constant (16)
  - the nibble-mask expansion function
- Sub-module spram_macro wraps one 16-bit macro.
  - Simulation build: behavioural array with nibble masks.
  - FPGA build: SP256K instance.
  - Top level instantiates an N_BANKS x COLS generate grid of spram_macro.

Test Plan (default parameters unless noted):
- Clear and idle: reset, wait.
  - init_done rises exactly 16384 cycles after rst deasserts.
  - req_ready is 0 before that.
  - Read of byte address 0x0001_FFFC returns 0x0000_0000.
- Bank boundary: write 0xDEADBEEF @0x0000_FFFC and 0xCAFEF00D @0x0001_0000, then read both back-to-back.
  - rsp_valid on 2 consecutive cycles with the correct data, proving rmux selection per bank.
- Byte masks: write 0xFFFFFFFF with mask 0xF, then write 0x00000000 with mask 0x5, then read.
  - Result is 0xFF00FF00.
- Pipelined stream with OUT_REG=1: 8 back-to-back reads.
  - 8 responses in order, each exactly 2 cycles after its acceptance.
- Error: read @0x0002_0000.
  - rsp_err = 1 and rsp_rdata unchanged.
  - Subsequent read of 0x0 is unaffected.
- Reset mid-operation:
  - rst pulsed at clear cycle 5000 gives a full 16384-cycle sweep afterwards.
  - rst pulsed with a read in flight gives no rsp_valid.
